water_supply_controller: RTL

Fill/hold controller for the water tank: consumes the three level sensors and the `conflict` flag from the sensor checker, and drives the inlet valve and the downstream supply enable. A four-state machine fills the tank with hysteresis from below mid level up to high level. It latches a fault on a persistent sensor conflict or a stalled fill, and holds the fault until an operator clear.

---
 rtl/water_supply_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/water_supply_controller.sv
// Fill/hold controller for the water tank: drives the inlet valve and supply enable
// from three level sensors, latching conflict and fill-timeout faults until cleared.
module water_supply_controller #(
    parameter int FILL_TIMEOUT    = 1000,
    parameter int CONFLICT_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       low_level,
    input  logic       mid_level,
    input  logic       high_level,
    input  logic       conflict,
    input  logic       fault_clear,
    output logic       valve_open,
    output logic       supply_enable,
    output logic       alarm,
    output logic [1:0] fault_code,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        HOLD  = 2'b10,
        FAULT = 2'b11
    } state_t;

    localparam int CW = $clog2(CONFLICT_CYCLES + 1);
    localparam int FW = $clog2(FILL_TIMEOUT + 1);

    localparam logic [CW-1:0] CONFLICT_LAST = CW'(CONFLICT_CYCLES - 1);
    localparam logic [CW-1:0] CONFLICT_MAX  = CW'(CONFLICT_CYCLES);
    localparam logic [FW-1:0] FILL_LAST     = FW'(FILL_TIMEOUT - 1);
    localparam logic [FW-1:0] FILL_MAX      = FW'(FILL_TIMEOUT);

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_CONFLICT = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    fault_code_q;
    logic [1:0]    fault_code_d;
    logic [CW-1:0] conflict_count;
    logic [CW-1:0] conflict_count_d;
    logic [FW-1:0] fill_count;
    logic [FW-1:0] fill_count_d;
    logic [2:0]    prev_level;
    logic [2:0]    levels;
    logic          low_q;
    logic          rise;
    logic          conflict_fault;
    logic          timeout;

    // A rise on any sensor counts as fill progress and defers the timeout.
    always_comb begin
        levels         = {high_level, mid_level, low_level};
        rise           = |(levels & ~prev_level);
        conflict_fault = (state_q != FAULT) && conflict && (conflict_count == CONFLICT_LAST);
        timeout        = (state_q == FILL) && (fill_count == FILL_LAST) && !rise;
    end

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        if (conflict_fault) begin
            state_d      = FAULT;
            fault_code_d = CODE_CONFLICT;
        end else begin
            unique case (state_q)
                IDLE:  state_d = high_level ? HOLD : FILL;
                FILL: begin
                    if (high_level) begin
                        state_d = HOLD;
                    end else if (timeout) begin
                        state_d      = FAULT;
                        fault_code_d = CODE_TIMEOUT;
                    end
                end
                HOLD:  if (!mid_level) state_d = FILL;
                FAULT: begin
                    if (fault_clear && !conflict) begin
                        state_d      = IDLE;
                        fault_code_d = CODE_NONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        conflict_count_d = '0;
        if (state_q != FAULT && conflict) begin
            conflict_count_d = (conflict_count == CONFLICT_MAX) ? CONFLICT_MAX
                                                                : conflict_count + 1'b1;
        end

        fill_count_d = '0;
        if (state_d == FILL && state_q == FILL && !rise) begin
            fill_count_d = (fill_count == FILL_MAX) ? FILL_MAX : fill_count + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            fault_code_q   <= CODE_NONE;
            conflict_count <= '0;
            fill_count     <= '0;
            prev_level     <= '0;
            low_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            fault_code_q   <= fault_code_d;
            conflict_count <= conflict_count_d;
            fill_count     <= fill_count_d;
            prev_level     <= levels;
            low_q          <= low_level;
        end
    end

    always_comb begin
        valve_open    = (state_q == FILL);
        alarm         = (state_q == FAULT);
        supply_enable = ((state_q == FILL) || (state_q == HOLD)) && low_q;
        fault_code    = fault_code_q;
        state         = state_q;
    end

endmodule
